// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and opcode constants for the ALU command sequencer and its FIFO.
package alu_cmd_sequencer_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_NOT = 4'b0101;
    localparam logic [OP_W-1:0] OP_INC = 4'b0110;
    localparam logic [OP_W-1:0] OP_DEC = 4'b0111;
    localparam logic [OP_W-1:0] OP_SHL = 4'b1000;
    localparam logic [OP_W-1:0] OP_SHR = 4'b1001;
    localparam logic [OP_W-1:0] OP_EQ  = 4'b1010;
    localparam logic [OP_W-1:0] OP_LAST = OP_EQ;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              use_acc;
    } cmd_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op > OP_LAST;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; a push into a full FIFO is refused even when a pop occurs the same cycle.
module alu_cmd_fifo
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_flush,
    input  cmd_t i_wdata,
    output cmd_t o_rdata,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    cmd_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit ALU: queues commands, drives the ALU from the FIFO head,
// registers results into a valid/ready output slot and keeps a chaining accumulator.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_use_acc,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zf,
    output logic              out_err,
    output logic [DATA_W-1:0] acc_value,
    output logic              busy
);

    slot_state_t       r_state;
    logic [DATA_W-1:0] r_out_result;
    logic              r_out_zf;
    logic              r_out_err;
    logic [DATA_W-1:0] r_acc;
    cmd_t              w_wdata;
    cmd_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_fire;

    assign w_wdata = '{op: in_op, a: in_a, b: in_b, use_acc: in_use_acc};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_pop   (w_fire),
        .i_flush (flush),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign in_ready   = !w_full;
    assign out_valid  = (r_state == SLOT_FULL);
    assign out_result = r_out_result;
    assign out_zf     = r_out_zf;
    assign out_err    = r_out_err;
    assign acc_value  = r_acc;
    assign busy       = !w_empty || out_valid;
    assign w_fire     = !w_empty && (!out_valid || out_ready) && !flush;

    // ALU operands come straight from the head; the accumulator already reflects the previous issue.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (!w_empty) begin
            alu_op = w_head.op;
            alu_b  = w_head.b;
            alu_a  = w_head.use_acc ? r_acc : w_head.a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SLOT_EMPTY;
            r_out_result <= '0;
            r_out_zf     <= 1'b0;
            r_out_err    <= 1'b0;
            r_acc        <= '0;
        end else begin
            if (w_fire) begin
                r_out_result <= alu_result;
                r_out_zf     <= alu_zf;
                r_out_err    <= op_illegal(w_head.op);
                r_acc        <= alu_result;
            end
            case (r_state)
                SLOT_EMPTY: if (w_fire) r_state <= SLOT_FULL;
                SLOT_FULL:  if (out_ready && !w_fire) r_state <= SLOT_EMPTY;
                default:    r_state <= SLOT_EMPTY;
            endcase
        end
    end

endmodule
